// File: rtl/snake_pkg.sv
// Shared constants for the snake body datapath:
// direction codes, default grid/body sizes, FSM states.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int GRID_W_DEF  = 32;
    localparam int GRID_H_DEF  = 24;
    localparam int MAX_LEN_DEF = 64;
    localparam int INIT_LEN    = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CALC   = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

endpackage

// File: rtl/snake_body_ram.sv
// Single-port body memory, MAX_LEN x (XW+YW), sync write, registered read.
// Ports: clk, init (load start body), we, addr, wdata, rdata.
module snake_body_ram
    import snake_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int XW      = 5,
    parameter int YW      = 5,
    parameter int AW      = 6
) (
    input  logic             clk,
    input  logic             init,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [XW+YW-1:0] wdata,
    output logic [XW+YW-1:0] rdata
);

    logic [XW+YW-1:0] mem [MAX_LEN];

    // Start body: entry 0 is the tail, entry INIT_LEN-1 the head,
    // stacked vertically below the grid centre.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < INIT_LEN; k++) begin
                mem[k] <= {XW'(GRID_W / 2),
                           YW'(GRID_H / 2 + INIT_LEN - 1 - k)};
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// Move sequencer: next head, wall/self collision scan, grow/shift commit,
// and arbitration of the body RAM between the scan and renderer reads.
// Ports: Clk/Resetn/Restart, Step/Dirn/Food_*, Busy/Done/Ate/Collide/Full,
//        Head_*/Length, Rd_Idx -> Rd_X/Rd_Y/Rd_Valid (1-cycle latency).
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int XW      = 5,
    parameter int YW      = 5,
    parameter int LW      = 7
) (
    input  logic          Clk,
    input  logic          Resetn,
    input  logic          Restart,
    input  logic          Step,
    input  logic [1:0]    Dirn,
    input  logic [XW-1:0] Food_X,
    input  logic [YW-1:0] Food_Y,
    output logic          Busy,
    output logic          Done,
    output logic          Ate,
    output logic          Collide,
    output logic          Full,
    output logic [XW-1:0] Head_X,
    output logic [YW-1:0] Head_Y,
    output logic [LW-1:0] Length,
    input  logic [LW-1:0] Rd_Idx,
    output logic [XW-1:0] Rd_X,
    output logic [YW-1:0] Rd_Y,
    output logic          Rd_Valid
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int DW = XW + YW;

    logic [2:0]    state;
    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          eat;
    logic          wall;
    logic          hit;
    logic          ate_q;
    logic          collide;
    logic          full;
    logic          scan_vld;
    logic [AW-1:0] scan_addr_q;
    logic          rd_valid;

    logic          rst;
    logic [XW-1:0] cnx;
    logic [YW-1:0] cny;
    logic          cwall;
    logic          ceat;
    logic          grant;
    logic          rd_ok;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] scan_addr;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] rdata;
    logic          match;
    logic          final_hit;

    // Segment k sits k entries behind head_ptr in the ring.
    function automatic logic [AW-1:0] ptr_back(
        input logic [AW-1:0] p,
        input logic [LW-1:0] k
    );
        logic [LW:0] s;
        s = (LW+1)'(p) + (LW+1)'(MAX_LEN) - (LW+1)'(k);
        if (s >= (LW+1)'(MAX_LEN)) begin
            s = s - (LW+1)'(MAX_LEN);
        end
        return AW'(s);
    endfunction

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rst = !Resetn || Restart;

    always_comb begin
        cnx   = hx;
        cny   = hy;
        cwall = 1'b0;
        unique case (Dirn)
            DIR_UP: begin
                cwall = (hy == '0);
                cny   = hy - 1'b1;
            end
            DIR_DOWN: begin
                cwall = (hy == YW'(GRID_H - 1));
                cny   = hy + 1'b1;
            end
            DIR_LEFT: begin
                cwall = (hx == '0);
                cnx   = hx - 1'b1;
            end
            DIR_RIGHT: begin
                cwall = (hx == XW'(GRID_W - 1));
                cnx   = hx + 1'b1;
            end
        endcase
    end

    assign ceat = (cnx == Food_X) && (cny == Food_Y);

    assign grant = (state == S_IDLE) || (state == S_CALC)
                || (state == S_DONE);
    assign rd_ok   = (Rd_Idx < len);
    assign rd_addr = ptr_back(head_ptr, rd_ok ? Rd_Idx : '0);

    assign scan_addr = ptr_back(head_ptr, idx);
    assign wr_addr   = ptr_next(head_ptr);

    // RAM read data lags the scan address by one cycle; the tail is
    // skipped when not eating because it vacates on this move.
    assign match = scan_vld
                && (rdata == {nx, ny})
                && (eat || (scan_addr_q != tail_ptr));

    // The last scan read is resolved in UPDATE, in front of the write.
    assign final_hit = hit || wall || match;
    assign ram_we    = (state == S_UPDATE) && !final_hit;

    always_comb begin
        ram_addr = rd_addr;
        if (ram_we) begin
            ram_addr = wr_addr;
        end else if (state == S_SCAN) begin
            ram_addr = scan_addr;
        end
    end

    snake_body_ram #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .MAX_LEN (MAX_LEN),
        .XW      (XW),
        .YW      (YW),
        .AW      (AW)
    ) u_ram (
        .clk   (Clk),
        .init  (rst),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata ({nx, ny}),
        .rdata (rdata)
    );

    always_ff @(posedge Clk) begin
        if (rst) begin
            state       <= S_IDLE;
            head_ptr    <= AW'(INIT_LEN - 1);
            tail_ptr    <= '0;
            len         <= LW'(INIT_LEN);
            idx         <= '0;
            hx          <= XW'(GRID_W / 2);
            hy          <= YW'(GRID_H / 2);
            nx          <= '0;
            ny          <= '0;
            eat         <= 1'b0;
            wall        <= 1'b0;
            hit         <= 1'b0;
            ate_q       <= 1'b0;
            collide     <= 1'b0;
            full        <= 1'b0;
            scan_vld    <= 1'b0;
            scan_addr_q <= '0;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid    <= grant && rd_ok;
            scan_vld    <= (state == S_SCAN);
            scan_addr_q <= scan_addr;
            unique case (state)
                S_IDLE: begin
                    if (Step && !collide && !full) begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    nx    <= cnx;
                    ny    <= cny;
                    eat   <= ceat;
                    wall  <= cwall;
                    hit   <= 1'b0;
                    ate_q <= 1'b0;
                    idx   <= '0;
                    state <= cwall ? S_UPDATE : S_SCAN;
                end
                S_SCAN: begin
                    if (match) begin
                        hit <= 1'b1;
                    end
                    idx <= idx + 1'b1;
                    if (idx == len - 1'b1) begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (final_hit) begin
                        collide <= 1'b1;
                    end else begin
                        head_ptr <= wr_addr;
                        hx       <= nx;
                        hy       <= ny;
                        if (eat) begin
                            len   <= len + 1'b1;
                            ate_q <= 1'b1;
                            full  <= (len + 1'b1 == LW'(MAX_LEN));
                        end else begin
                            tail_ptr <= ptr_next(tail_ptr);
                        end
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy     = (state != S_IDLE);
    assign Done     = (state == S_DONE);
    assign Ate      = (state == S_DONE) && ate_q;
    assign Collide  = collide;
    assign Full     = full;
    assign Head_X   = hx;
    assign Head_Y   = hy;
    assign Length   = len;
    assign Rd_X     = rdata[DW-1:YW];
    assign Rd_Y     = rdata[YW-1:0];
    assign Rd_Valid = rd_valid;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: directed scenarios plus random moves
// checked against a queue-based model of the snake body.
module tb_snake_body_ctrl;
    import snake_pkg::*;

    localparam int GW = 32;
    localparam int GH = 24;
    localparam int ML = 8;
    localparam int XW = 5;
    localparam int YW = 5;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          Resetn = 1'b0;
    logic          Restart = 1'b0;
    logic          Step = 1'b0;
    logic [1:0]    Dirn = 2'b00;
    logic [XW-1:0] Food_X = '0;
    logic [YW-1:0] Food_Y = '0;
    logic          Busy, Done, Ate, Collide, Full;
    logic [XW-1:0] Head_X;
    logic [YW-1:0] Head_Y;
    logic [LW-1:0] Length;
    logic [LW-1:0] Rd_Idx = '0;
    logic [XW-1:0] Rd_X;
    logic [YW-1:0] Rd_Y;
    logic          Rd_Valid;

    always #5 clk = ~clk;

    snake_body_ctrl #(
        .GRID_W (GW), .GRID_H (GH), .MAX_LEN (ML),
        .XW (XW), .YW (YW), .LW (LW)
    ) dut (
        .Clk (clk), .Resetn (Resetn), .Restart (Restart),
        .Step (Step), .Dirn (Dirn),
        .Food_X (Food_X), .Food_Y (Food_Y),
        .Busy (Busy), .Done (Done), .Ate (Ate),
        .Collide (Collide), .Full (Full),
        .Head_X (Head_X), .Head_Y (Head_Y), .Length (Length),
        .Rd_Idx (Rd_Idx), .Rd_X (Rd_X), .Rd_Y (Rd_Y),
        .Rd_Valid (Rd_Valid)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: bx[0]/by[0] is the head, last entry the tail.
    int bx[$];
    int by[$];
    bit m_col;
    bit m_full;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        bx = {GW / 2, GW / 2, GW / 2};
        by = {GH / 2, GH / 2 + 1, GH / 2 + 2};
        m_col  = 1'b0;
        m_full = 1'b0;
    endtask

    function automatic int step_x(input int d, input int x);
        return x + ((d == 3) ? 1 : 0) - ((d == 2) ? 1 : 0);
    endfunction

    function automatic int step_y(input int d, input int y);
        return y + ((d == 1) ? 1 : 0) - ((d == 0) ? 1 : 0);
    endfunction

    task automatic m_move(input int d, input int fx, input int fy,
                          output int cyc, output bit ate);
        int nx, ny, n;
        bit eat, hit;
        nx  = step_x(d, bx[0]);
        ny  = step_y(d, by[0]);
        ate = 1'b0;
        hit = 1'b0;
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            m_col = 1'b1;
            cyc   = 3;
            return;
        end
        cyc = bx.size() + 3;
        eat = (nx == fx) && (ny == fy);
        n   = eat ? bx.size() : bx.size() - 1;
        for (int i = 0; i < n; i++) begin
            if (bx[i] == nx && by[i] == ny) hit = 1'b1;
        end
        if (hit) begin
            m_col = 1'b1;
            return;
        end
        bx.push_front(nx);
        by.push_front(ny);
        if (eat) begin
            ate = 1'b1;
            if (bx.size() == ML) m_full = 1'b1;
        end else begin
            void'(bx.pop_back());
            void'(by.pop_back());
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_hx"}, Head_X, bx[0]);
        check({tag, "_hy"}, Head_Y, by[0]);
        check({tag, "_len"}, Length, bx.size());
        check({tag, "_col"}, Collide, m_col);
        check({tag, "_full"}, Full, m_full);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Resetn = 1'b0;
        Step   = 1'b0;
        @(negedge clk);
        Resetn = 1'b1;
        m_reset();
    endtask

    task automatic do_step(input int d, input int fx, input int fy);
        int  cyc, n, seen;
        bit  ate, live;
        live = !m_col && !m_full;
        @(negedge clk);
        Dirn   = 2'(d);
        Food_X = XW'(fx);
        Food_Y = YW'(fy);
        Step   = 1'b1;
        @(negedge clk);
        Step = 1'b0;
        n    = 1;
        if (!live) begin
            seen = 0;
            repeat (12) begin
                if (Done) seen++;
                @(negedge clk);
            end
            check("ignored_done", seen, 0);
            check("ignored_busy", Busy, 0);
            return;
        end
        check("busy", Busy, 1);
        m_move(d, fx, fy, cyc, ate);
        while (!Done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_cyc", n, cyc);
        check("ate", Ate, ate);
        check_state("step");
    endtask

    task automatic rd_check(input int idx);
        bit v;
        @(negedge clk);
        Rd_Idx = LW'(idx);
        @(negedge clk);
        v = (idx < bx.size());
        check("rd_valid", Rd_Valid, v);
        if (v) begin
            check("rd_x", Rd_X, bx[idx]);
            check("rd_y", Rd_Y, by[idx]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, rev, fx, fy, nx, ny, seen;

        // Reset state and start body
        do_reset();
        check("rst_rdv", Rd_Valid, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_ate", Ate, 0);
        check_state("rst");
        for (int i = 0; i <= 3; i++) rd_check(i);

        // Plain move up, no food
        do_step(0, 0, 0);
        rd_check(2);

        // Eat on first move
        do_reset();
        do_step(0, GW / 2, GH / 2 - 1);
        rd_check(3);

        // Run into the top wall
        do_reset();
        repeat (12) do_step(0, 0, 0);
        check("top_y", Head_Y, 0);
        do_step(0, 0, 0);
        check("wall_col", Collide, 1);
        do_step(3, 0, 0);

        // Length 5 loop collides with own body
        do_reset();
        do_step(0, 16, 11);
        do_step(0, 16, 10);
        do_step(2, 0, 0);
        do_step(1, 0, 0);
        do_step(3, 0, 0);
        check("loop5_col", Collide, 1);

        // Length 4 loop chases its tail safely
        do_reset();
        do_step(0, 16, 11);
        do_step(2, 0, 0);
        do_step(1, 0, 0);
        do_step(3, 0, 0);
        check("loop4_col", Collide, 0);
        for (int i = 0; i < 4; i++) rd_check(i);

        // Fill the body
        do_reset();
        for (int k = 1; k <= ML - 3; k++) do_step(0, 16, 12 - k);
        check("full_flag", Full, 1);
        check("full_len", Length, ML);
        do_step(0, 0, 0);
        rd_check(ML - 1);

        // Restart mid-scan, also racing a Step
        do_reset();
        do_step(2, 0, 0);
        @(negedge clk);
        Dirn = 2'(0);
        Step = 1'b1;
        @(negedge clk);
        Step = 1'b0;
        @(negedge clk);
        Rd_Idx = '0;
        @(negedge clk);
        check("scan_rdv", Rd_Valid, 0);
        check("scan_busy", Busy, 1);
        Restart = 1'b1;
        Step    = 1'b1;
        @(negedge clk);
        Restart = 1'b0;
        Step    = 1'b0;
        m_reset();
        check("rs_busy", Busy, 0);
        check_state("rs");
        seen = 0;
        repeat (10) begin
            if (Done) seen++;
            @(negedge clk);
        end
        check("rs_nodone", seen, 0);
        for (int i = 0; i < 3; i++) rd_check(i);

        // Random moves with pointer wrap
        do_reset();
        for (int it = 0; it < 300; it++) begin
            if (m_col || m_full) begin
                if (($urandom % 2) == 0) do_step($urandom % 4, 0, 0);
                do_reset();
            end
            rev = (by[1] < by[0]) ? 0 :
                  (by[1] > by[0]) ? 1 :
                  (bx[1] < bx[0]) ? 2 : 3;
            do begin
                d = $urandom % 4;
            end while (d == rev && ($urandom % 8) != 0);
            nx = step_x(d, bx[0]);
            ny = step_y(d, by[0]);
            if (($urandom % 4) == 0 && nx >= 0 && nx < GW
                && ny >= 0 && ny < GH) begin
                fx = nx;
                fy = ny;
            end else begin
                fx = $urandom_range(0, GW - 1);
                fy = $urandom_range(0, GH - 1);
            end
            do_step(d, fx, fy);
            rd_check($urandom_range(0, ML));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
